// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter for NUM_MASTERS requesters.
// Ownership moves only at legal AHB boundaries. These are single transfers,
// IDLE cycles, the last beat of a fixed-length burst, or the early end of a
// burst. Fixed-length bursts are never split between masters.
// Optional build macro: AHB_ARB_LOCK_EN adds the `lock` input (muxed
// HMASTLOCK). While lock is high at an arbitration point, the current owner
// keeps the bus.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int ID_W           = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             trans,
  input  logic [2:0]             burst,
  input  logic                   ready,
`ifdef AHB_ARB_LOCK_EN
  input  logic                   lock,
`endif
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        master_id,
  output logic [ID_W-1:0]        data_master_id,
  output logic                   burst_active
);

  // HTRANS encodings
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  // HBURST encodings that matter here; 2..7 are the fixed-length bursts
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  typedef enum logic [1:0] {
    S_OPEN  = 2'd0,
    S_BURST = 2'd1,
    S_INCR  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_beat_cnt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [ID_W-1:0]        r_master_id;
  logic [ID_W-1:0]        r_data_master_id;

  state_t                 w_next_state;
  logic [3:0]             w_next_cnt;
  logic                   w_arb;
  logic                   w_open_eval;
  logic                   w_found;
  logic [ID_W-1:0]        w_winner;
  logic [ID_W-1:0]        w_idx;
  logic                   w_lock;
  logic [NUM_MASTERS-1:0] w_winner_onehot;

`ifdef AHB_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Number of SEQ beats that follow the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] seq_beats(input logic [2:0] b);
    logic [3:0] n;
    case (b[2:1])
      2'b01:   n = 4'd3;   // WRAP4 / INCR4
      2'b10:   n = 4'd7;   // WRAP8 / INCR8
      2'b11:   n = 4'd15;  // WRAP16 / INCR16
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Round-robin search: start one past the owner, wrap, owner checked last
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_master_id;
    w_idx    = r_master_id;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_idx = ID_W'((int'(r_master_id) + i) % NUM_MASTERS);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // One-hot grant vector for the search winner
  always_comb begin
    w_winner_onehot           = '0;
    w_winner_onehot[w_winner] = 1'b1;
  end

  // Next-state decision: burst tracking and detection of arbitration points
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_beat_cnt;
    w_arb        = 1'b0;
    w_open_eval  = 1'b0;

    case (r_state)
      S_OPEN: begin
        w_open_eval = 1'b1;
      end
      S_BURST: begin
        if (trans == TR_SEQ) begin
          w_next_cnt = r_beat_cnt - 4'd1;
          if (r_beat_cnt == 4'd1) begin
            // last beat address accepted: hand over for the next address phase
            w_arb        = 1'b1;
            w_next_state = S_OPEN;
          end
        end else if (trans != TR_BUSY) begin
          // IDLE or NONSEQ inside a fixed burst means early termination
          w_open_eval = 1'b1;
        end
      end
      S_INCR: begin
        if (trans == TR_IDLE || trans == TR_NONSEQ) begin
          w_open_eval = 1'b1;
        end
      end
      default: begin
        w_next_state = S_OPEN;
        w_next_cnt   = '0;
      end
    endcase

    if (w_open_eval) begin
      w_next_state = S_OPEN;
      w_next_cnt   = '0;
      if (trans == TR_NONSEQ) begin
        if (burst == BU_SINGLE) begin
          w_arb = 1'b1;
        end else if (burst == BU_INCR) begin
          w_next_state = S_INCR;
        end else begin
          w_next_state = S_BURST;
          w_next_cnt   = seq_beats(burst);
        end
      end else if (trans == TR_IDLE) begin
        w_arb = 1'b1;
      end
      // BUSY/SEQ with no burst open is illegal: hold the current grant
    end
  end

  // Arbiter state and registered outputs; everything holds while ready is low
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state          <= S_OPEN;
      r_beat_cnt       <= '0;
      r_grant          <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      r_master_id      <= ID_W'(DEFAULT_MASTER);
      r_data_master_id <= ID_W'(DEFAULT_MASTER);
    end else if (ready) begin
      r_state          <= w_next_state;
      r_beat_cnt       <= w_next_cnt;
      r_data_master_id <= r_master_id;
      if (w_arb && !w_lock && w_found) begin
        r_grant     <= w_winner_onehot;
        r_master_id <= w_winner;
      end
    end
  end

  assign grant          = r_grant;
  assign master_id      = r_master_id;
  assign data_master_id = r_data_master_id;
  assign burst_active   = (r_state != S_OPEN);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Testbench for ahb_arbiter (NUM_MASTERS=4, DEFAULT_MASTER=0).
// The reference model tracks the owner, the burst kind and the beats left
// using plain integers, and applies the round-robin rule by search.
module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req;
  logic [1:0]    trans;
  logic [2:0]    burst;
  logic          ready;
  logic          lock_i;
  logic [N-1:0]  grant;
  logic [IW-1:0] master_id;
  logic [IW-1:0] data_master_id;
  logic          burst_active;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_owner;       // address-phase owner
  int m_data_owner;  // data-phase owner
  int m_mode;        // 0 no burst, 1 fixed-length burst, 2 INCR
  int m_left;        // SEQ beats still expected in a fixed burst

  always #5 clk = ~clk;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req            (req),
    .trans          (trans),
    .burst          (burst),
    .ready          (ready),
`ifdef AHB_ARB_LOCK_EN
    .lock           (lock_i),
`endif
    .grant          (grant),
    .master_id      (master_id),
    .data_master_id (data_master_id),
    .burst_active   (burst_active)
  );

  task automatic model_update();
    logic lk;
    bit   open_eval;
    bit   arb;
    bit   found;
    int   b;
    int   c;
`ifdef AHB_ARB_LOCK_EN
    lk = lock_i;
`else
    lk = 1'b0;
`endif
    if (!rstn) begin
      m_owner = 0; m_data_owner = 0; m_mode = 0; m_left = 0;
    end else if (ready) begin
      m_data_owner = m_owner;
      open_eval = 0;
      arb = 0;
      if (m_mode == 1) begin
        if (trans == 2'd3) begin
          m_left = m_left - 1;
          if (m_left == 0) begin arb = 1; m_mode = 0; end
        end else if (trans != 2'd1) begin
          open_eval = 1;
        end
      end else if (m_mode == 2) begin
        if (trans == 2'd0 || trans == 2'd2) open_eval = 1;
      end else begin
        open_eval = 1;
      end
      if (open_eval) begin
        m_mode = 0;
        if (trans == 2'd2) begin
          b = int'(burst);
          if (b >= 2) begin
            m_mode = 1;
            m_left = (2 << (b >> 1)) - 1;
          end else if (b == 1) begin
            m_mode = 2;
          end else begin
            arb = 1;
          end
        end else if (trans == 2'd0) begin
          arb = 1;
        end
      end
      if (arb && !lk) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (!found && req[c]) begin
            found = 1;
            m_owner = c;
          end
        end
      end
    end
  endtask

  // drive one cycle of inputs, clock it, advance the model, settle
  task automatic step(input logic rn, input logic [N-1:0] rq, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rd, input logic lk);
    @(negedge clk);
    rstn = rn; req = rq; trans = tr; burst = bu; ready = rd; lock_i = lk;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 2'(i), 3'd3, 1'b1, 1'b0);
      n_cmp++;
      if (grant !== 4'b0001 || master_id !== 2'd0 || data_master_id !== 2'd0 ||
          burst_active !== 1'b0) begin
        n_bad++;
        $display("FAIL reset cycle %0d: grant=%b id=%0d did=%0d ba=%b, want 0001 0 0 0",
                 i, grant, master_id, data_master_id, burst_active);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [4];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0100; exp_g[2] = 4'b1000; exp_g[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b1, 4'b1110, 2'd0, 3'd0, 1'b1, 1'b0);
      else        step(1'b1, 4'b1110, 2'd2, 3'd0, 1'b1, 1'b0);
      n_cmp++;
      if (grant !== exp_g[i] || burst_active !== 1'b0) begin
        n_bad++;
        $display("FAIL round_robin step %0d: grant=%b ba=%b, want grant=%b ba=0",
                 i, grant, burst_active, exp_g[i]);
      end
    end
  endtask

  task automatic test_incr8_wait();
    // NONSEQ, 2 SEQ, 2 wait cycles, 4 SEQ, final SEQ
    step(1'b1, 4'b1111, 2'd2, 3'd5, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 4'b0010 || burst_active !== 1'b1) begin
      n_bad++;
      $display("FAIL incr8 nonseq: grant=%b ba=%b, want 0010 1", grant, burst_active);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1111, 2'd3, 3'd5, (i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b0);
      n_cmp++;
      if (grant !== 4'b0010 || burst_active !== 1'b1) begin
        n_bad++;
        $display("FAIL incr8 mid %0d: grant=%b ba=%b, want 0010 1", i, grant, burst_active);
      end
    end
    step(1'b1, 4'b1111, 2'd3, 3'd5, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 4'b0100 || master_id !== 2'd2 || data_master_id !== 2'd1 ||
        burst_active !== 1'b0) begin
      n_bad++;
      $display("FAIL incr8 last: grant=%b id=%0d did=%0d ba=%b, want 0100 2 1 0",
               grant, master_id, data_master_id, burst_active);
    end
  endtask

  task automatic test_early_term();
    step(1'b1, 4'b1000, 2'd2, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1000, 2'd3, 3'd7, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 4'b0100 || burst_active !== 1'b1) begin
      n_bad++;
      $display("FAIL early_term mid: grant=%b ba=%b, want 0100 1", grant, burst_active);
    end
    step(1'b1, 4'b1000, 2'd0, 3'd7, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 4'b1000 || master_id !== 2'd3 || burst_active !== 1'b0) begin
      n_bad++;
      $display("FAIL early_term end: grant=%b id=%0d ba=%b, want 1000 3 0",
               grant, master_id, burst_active);
    end
  endtask

  task automatic test_park();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
      n_cmp++;
      if (grant !== 4'b1000) begin
        n_bad++;
        $display("FAIL park idle %0d: grant=%b, want 1000", i, grant);
      end
    end
    step(1'b1, 4'b0001, 2'd0, 3'd0, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 4'b0001 || master_id !== 2'd0) begin
      n_bad++;
      $display("FAIL park wake: grant=%b id=%0d, want 0001 0", grant, master_id);
    end
  endtask

  task automatic test_ready_hold();
    logic [N-1:0] eg;
    step(1'b1, 4'b1111, 2'd0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 2'd2, 3'd0, 1'b0, 1'b0);
    eg = '0; eg[m_owner] = 1'b1;
    n_cmp++;
    if (grant !== eg || master_id !== IW'(m_owner) || data_master_id !== IW'(m_data_owner)) begin
      n_bad++;
      $display("FAIL ready_hold: grant=%b id=%0d did=%0d, want %b %0d %0d",
               grant, master_id, data_master_id, eg, m_owner, m_data_owner);
    end
  endtask

`ifdef AHB_ARB_LOCK_EN
  task automatic test_lock();
    step(1'b0, 4'b0000, 2'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0011, 2'd2, 3'd0, 1'b1, 1'b1);
      n_cmp++;
      if (grant !== 4'b0001) begin
        n_bad++;
        $display("FAIL lock held %0d: grant=%b, want 0001", i, grant);
      end
    end
    step(1'b1, 4'b0011, 2'd2, 3'd0, 1'b1, 1'b0);
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_bad++;
      $display("FAIL lock release: grant=%b, want 0010", grant);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] eg;
    logic [1:0]   tr;
    int           r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      tr = (r < 2) ? 2'd0 : (r == 2) ? 2'd1 : (r < 5) ? 2'd2 : 2'd3;
      step(($urandom_range(0, 127) != 0), 4'($urandom), tr, 3'($urandom),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
      eg = '0; eg[m_owner] = 1'b1;
      n_cmp++;
      if ({grant, master_id, data_master_id, burst_active} !==
          {eg, IW'(m_owner), IW'(m_data_owner), (m_mode != 0)}) begin
        n_bad++;
        $display("FAIL random cycle %0d: grant=%b id=%0d did=%0d ba=%b, want %b %0d %0d %0d",
                 i, grant, master_id, data_master_id, burst_active,
                 eg, m_owner, m_data_owner, (m_mode != 0));
      end
    end
  endtask

  initial begin
    rstn = 1'b0; req = '0; trans = 2'd0; burst = 3'd0; ready = 1'b1; lock_i = 1'b0;
    m_owner = 0; m_data_owner = 0; m_mode = 0; m_left = 0;
    test_reset();
    test_round_robin();
    test_incr8_wait();
    test_early_term();
    test_park();
    test_ready_hold();
`ifdef AHB_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
